// File: rtl/g15_timing_pkg.sv
// Shared types and widths for the drum timing track emulation.
package g15_timing_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        FREEZE_PEND = 2'd1,
        FROZEN      = 2'd2,
        STEP        = 2'd3
    } timing_state_t;

    localparam int BIT_W             = 5;
    localparam int WORD_W            = 7;
    localparam int DEF_BITS_PER_WORD = 29;
    localparam int DEF_WORDS_PER_REV = 108;

endpackage

// File: rtl/bit_prescaler.sv
// Bit-rate prescaler: one tick every CLK_DIV clocks while enabled, parked at 0 otherwise.
module bit_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic CLOCK,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          at_top;

    assign at_top = (cnt == CW'(CLK_DIV - 1));
    assign tick   = enable && at_top;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!enable)
            cnt <= '0;
        else if (at_top)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/drum_timing_seq.sv
// Drum timing sequencer: bit/word counters, T-strobe decode and freeze/step handshake.
module drum_timing_seq
    import g15_timing_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
    parameter int WORDS_PER_REV = DEF_WORDS_PER_REV
) (
    input  logic              CLOCK,
    input  logic              rst_n,
    input  logic              freeze_req,
    input  logic              step_word,
    output logic              freeze_ack,
    output logic              bit_tick,
    output logic [BIT_W-1:0]  bit_num,
    output logic [WORD_W-1:0] word_num,
    output logic              T0,
    output logic              T1,
    output logic              T2,
    output logic              T13,
    output logic              T21,
    output logic              T28,
    output logic              word_odd,
    output logic              word_end,
    output logic              origin
);

    timing_state_t state, state_nxt;
    logic          last_bit;
    logic          word_done;

    bit_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
        .CLOCK  (CLOCK),
        .rst_n  (rst_n),
        .enable (state != FROZEN),
        .tick   (bit_tick)
    );

    assign last_bit  = (bit_num == BIT_W'(BITS_PER_WORD - 1));
    assign word_done = bit_tick && last_bit;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            bit_num  <= '0;
            word_num <= '0;
        end else if (bit_tick) begin
            if (last_bit) begin
                bit_num  <= '0;
                word_num <= (word_num == WORD_W'(WORDS_PER_REV - 1)) ? '0 : word_num + WORD_W'(1);
            end else begin
                bit_num  <= bit_num + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Freezes only ever land on a word boundary; releasing beats a same-cycle step.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:         if (freeze_req) state_nxt = FREEZE_PEND;
            FREEZE_PEND: begin
                if (!freeze_req)    state_nxt = RUN;
                else if (word_done) state_nxt = FROZEN;
            end
            FROZEN: begin
                if (!freeze_req)    state_nxt = RUN;
                else if (step_word) state_nxt = STEP;
            end
            STEP:        if (word_done) state_nxt = freeze_req ? FROZEN : RUN;
            default:     state_nxt = RUN;
        endcase
    end

    assign freeze_ack = (state == FROZEN);

    assign T0       = (bit_num == BIT_W'(0));
    assign T1       = (bit_num == BIT_W'(1));
    assign T2       = (bit_num == BIT_W'(2));
    assign T13      = (bit_num == BIT_W'(13));
    assign T21      = (bit_num == BIT_W'(21));
    assign T28      = (bit_num == BIT_W'(28));
    assign word_odd = word_num[0];
    assign word_end = T28;
    assign origin   = T0 && (word_num == '0);

endmodule

// File: tb/tb_drum_timing_seq.sv
// Directed bench for drum_timing_seq with CLK_DIV=4, 29 bits/word, 108 words/rev.
module tb_drum_timing_seq;

    logic       CLOCK = 1'b0;
    logic       rst_n = 1'b0;
    logic       freeze_req = 1'b0;
    logic       step_word = 1'b0;
    logic       freeze_ack, bit_tick;
    logic [4:0] bit_num;
    logic [6:0] word_num;
    logic       T0, T1, T2, T13, T21, T28, word_odd, word_end, origin;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLOCK = ~CLOCK;

    drum_timing_seq #(.CLK_DIV(4), .BITS_PER_WORD(29), .WORDS_PER_REV(108)) dut (
        .CLOCK(CLOCK), .rst_n(rst_n), .freeze_req(freeze_req), .step_word(step_word),
        .freeze_ack(freeze_ack), .bit_tick(bit_tick), .bit_num(bit_num), .word_num(word_num),
        .T0(T0), .T1(T1), .T2(T2), .T13(T13), .T21(T21), .T28(T28),
        .word_odd(word_odd), .word_end(word_end), .origin(origin)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance on falling edges until the counters show (w,b); expiry counts as a miss.
    task automatic wait_pos(input int w, input int b, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK);
            if (word_num == 7'(w) && bit_num == 5'(b)) return;
        end
        chk("wait_pos_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bit"}, bit_num, 0);
        chk({tag, "_word"}, word_num, 0);
        chk({tag, "_T0"}, T0, 1);
        chk({tag, "_origin"}, origin, 1);
        chk({tag, "_ack"}, freeze_ack, 0);
        chk({tag, "_tick"}, bit_tick, 0);
        chk({tag, "_odd"}, word_odd, 0);
        chk({tag, "_others"}, {T1, T2, T13, T21, T28, word_end}, 0);
    endtask

    initial begin
        int cnt, cyc, origins, wraps, toggles, bad_gap, last_tog, saw_ack;
        logic       prev_org, prev_odd;
        logic [6:0] prev_w;

        // Reset state
        #2;
        chk_reset_vals("rst");

        // First tick lands three edges after release; counters move on the fourth
        @(negedge CLOCK) rst_n = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("first_tick", bit_tick, 1);
        chk("first_tick_bit", bit_num, 0);
        chk("first_tick_T0", T0, 1);
        @(negedge CLOCK);
        chk("after_tick_bit", bit_num, 1);
        chk("after_tick_T1", T1, 1);
        chk("after_tick_quiet", bit_tick, 0);

        // One full revolution of free running
        origins = 0; wraps = 0; toggles = 0; bad_gap = 0; last_tog = -1;
        prev_org = origin; prev_odd = word_odd; prev_w = word_num;
        for (int i = 1; i <= 12528; i++) begin
            @(negedge CLOCK);
            if (origin && !prev_org) origins++;
            if (word_num != prev_w && word_num == 0 && prev_w == 107) wraps++;
            if (word_odd != prev_odd) begin
                toggles++;
                if (last_tog >= 0 && i - last_tog != 116) bad_gap++;
                last_tog = i;
            end
            prev_org = origin; prev_odd = word_odd; prev_w = word_num;
        end
        chk("rev_origins", origins, 1);
        chk("rev_wrap_107_0", wraps, 1);
        chk("rev_odd_toggles", toggles, 108);
        chk("rev_odd_gap", bad_gap, 0);
        chk("rev_bit", bit_num, 1);
        chk("rev_word", word_num, 0);

        // Freeze requested at word 5 bit 10
        wait_pos(5, 10, 20000);
        freeze_req = 1'b1;
        cnt = 0; cyc = 0;
        while (!freeze_ack && cyc < 200) begin
            if (bit_tick) cnt++;
            @(negedge CLOCK);
            cyc++;
        end
        chk("frz_ack", freeze_ack, 1);
        chk("frz_ticks", cnt, 19);
        chk("frz_latency_ok", cyc <= 120, 1);
        chk("frz_word", word_num, 6);
        chk("frz_bit", bit_num, 0);
        chk("frz_T0", T0, 1);
        cnt = 0; saw_ack = 1;
        repeat (20) begin
            chk("frz_no_tick", bit_tick, 0);
            @(negedge CLOCK);
            if (!freeze_ack) saw_ack = 0;
        end
        chk("frz_held", saw_ack, 1);
        chk("frz_static_bit", bit_num, 0);

        // Single step, with a stray step pulse mid-step that must be ignored
        step_word = 1'b1;
        @(negedge CLOCK) step_word = 1'b0;
        chk("step_ack_low", freeze_ack, 0);
        cnt = 0; cyc = 0;
        while (!freeze_ack && cyc < 200) begin
            if (bit_tick) cnt++;
            step_word = (cyc == 10);
            @(negedge CLOCK);
            cyc++;
        end
        step_word = 1'b0;
        chk("step_ticks", cnt, 29);
        chk("step_ack", freeze_ack, 1);
        chk("step_word", word_num, 7);
        chk("step_bit", bit_num, 0);
        chk("step_ack_tick_excl", freeze_ack & bit_tick, 0);

        // Release: first tick CLK_DIV cycles after the state leaves FROZEN
        freeze_req = 1'b0;
        @(negedge CLOCK);
        chk("rel_ack", freeze_ack, 0);
        cyc = 1;
        while (!bit_tick && cyc < 50) begin
            @(negedge CLOCK);
            cyc++;
        end
        chk("rel_first_tick", cyc, 4);
        chk("rel_bit", bit_num, 0);

        // Cancelled freeze: no ack, no lost tick across the word
        wait_pos(3, 4, 20000);
        freeze_req = 1'b1;
        cyc = 0; saw_ack = 0;
        while (!(word_num == 4 && bit_num == 0) && cyc < 400) begin
            @(negedge CLOCK);
            cyc++;
            if (freeze_ack) saw_ack = 1;
            if (word_num == 3 && bit_num == 20) freeze_req = 1'b0;
        end
        chk("cancel_no_ack", saw_ack, 0);
        chk("cancel_cycles", cyc, 100);
        chk("cancel_req_dropped", freeze_req, 0);

        // Reset in the middle of a step
        wait_pos(8, 0, 20000);
        freeze_req = 1'b1;
        cyc = 0;
        while (!freeze_ack && cyc < 200) begin
            @(negedge CLOCK);
            cyc++;
        end
        chk("pre_step_word", word_num, 9);
        step_word = 1'b1;
        @(negedge CLOCK) step_word = 1'b0;
        wait_pos(9, 12, 200);
        chk("mid_step_ack", freeze_ack, 0);
        rst_n = 1'b0;
        freeze_req = 1'b0;
        #1;
        chk_reset_vals("midstep_rst");
        @(negedge CLOCK) rst_n = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("post_rst_tick", bit_tick, 1);
        @(negedge CLOCK);
        chk("post_rst_bit", bit_num, 1);
        chk("post_rst_word", word_num, 0);
        chk("post_rst_ack", freeze_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
